// File: rtl/pw_pkg.sv
// pw_pkg: shared mode type, stage codes and default width for the password vault
package pw_pkg;
   typedef enum logic [1:0] {SETUP, ARMD, OPEN, LOCKOUT} vault_mode_t;
   localparam logic [1:0] STG_ENTER1 = 2'd0;
   localparam logic [1:0] STG_REC1   = 2'd1;
   localparam logic [1:0] STG_REC2   = 2'd2;
   localparam logic [1:0] STG_DONE   = 2'd3;
   localparam int DEF_PW_W = 8;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter whose done flag marks the end of a lockout
module lockout_timer #(
   parameter int LOCK_CYC = 1000
)(
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic done
);
   localparam int CW = $clog2(LOCK_CYC);
   logic [CW-1:0] cnt;
   // load the lockout length minus one, then count down to zero and rest there
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= CW'(LOCK_CYC - 1);
      else if (cnt != '0) cnt <= cnt - CW'(1);
   assign done = (cnt == '0);
endmodule

// File: rtl/pw_vault.sv
// pw_vault: records, confirms and checks a switch password with timed lockout after repeated failures
module pw_vault
   import pw_pkg::*;
#(
   parameter int PW_W     = DEF_PW_W,
   parameter int MAX_FAIL = 3,
   parameter int LOCK_CYC = 1000
)(
   input  logic            CLK,
   input  logic            RST,
   input  logic [1:0]      STAGE,
   input  logic [PW_W-1:0] PW,
   input  logic            CLR,
   output logic            UNLOCK,
   output logic            ARMED,
   output logic            LOCKED,
   output logic            ERR,
   output logic [2:0]      FAILS
);
   vault_mode_t     mode, mode_n;
   logic [1:0]      prev_stage;
   logic [PW_W-1:0] set_reg, set_n;
   logic [2:0]      fails_n, fails_inc;
   logic            err_n, load, done, match;
   logic            ev_set, ev_conf, ev_try, ev_exit;

   assign match     = (PW == set_reg);
   assign fails_inc = FAILS + 3'd1;
   assign ev_set    = (prev_stage == STG_ENTER1) && (STAGE == STG_REC1);
   assign ev_conf   = (prev_stage == STG_REC1)   && (STAGE == STG_REC2);
   assign ev_try    = (prev_stage == STG_REC2)   && (STAGE == STG_DONE);
   assign ev_exit   = (prev_stage == STG_DONE)   && (STAGE == STG_ENTER1);

   lockout_timer #(.LOCK_CYC(LOCK_CYC)) u_timer (
      .clk  (CLK),
      .rst  (RST),
      .load (load),
      .done (done)
   );

   // next mode, stored password, fail count and error pulse from the current stage advance
   always_comb begin
      mode_n  = mode;
      set_n   = set_reg;
      fails_n = FAILS;
      err_n   = 1'b0;
      load    = 1'b0;
      case (mode)
         SETUP: begin
            if (ev_set) set_n = PW;
            else if (ev_conf) begin
               if (match) mode_n = ARMD;
               else err_n = 1'b1;
            end
         end
         ARMD: begin
            if (ev_try) begin
               if (match) begin
                  mode_n  = OPEN;
                  fails_n = '0;
               end else begin
                  err_n   = 1'b1;
                  fails_n = fails_inc;
                  if (fails_inc == 3'(MAX_FAIL)) begin
                     mode_n = LOCKOUT;
                     load   = 1'b1;
                  end
               end
            end
         end
         OPEN: begin
            if (CLR) begin
               mode_n = SETUP;
               set_n  = '0;
            end else if (ev_exit) mode_n = ARMD;
         end
         default: begin
            if (done) begin
               mode_n  = ARMD;
               fails_n = '0;
            end
         end
      endcase
   end

   // state and outputs are registered together so every indicator comes straight from a flop
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         prev_stage <= STG_ENTER1;
         mode       <= SETUP;
         set_reg    <= '0;
         FAILS      <= '0;
         ERR        <= 1'b0;
         UNLOCK     <= 1'b0;
         ARMED      <= 1'b0;
         LOCKED     <= 1'b0;
      end else begin
         prev_stage <= STAGE;
         mode       <= mode_n;
         set_reg    <= set_n;
         FAILS      <= fails_n;
         ERR        <= err_n;
         UNLOCK     <= (mode_n == OPEN);
         ARMED      <= (mode_n == ARMD);
         LOCKED     <= (mode_n == LOCKOUT);
      end
endmodule

// File: tb/tb_pw_vault.sv
// tb_pw_vault: table vectors, hand-written corner sequences and a randomized run against a behavioural model
module tb_pw_vault;
   localparam int PW_W = 8, MAX_FAIL = 3, LOCK_CYC = 16;

   logic       CLK = 1'b0, RST = 1'b1, CLR = 1'b0;
   logic [1:0] STAGE = 2'd0;
   logic [7:0] PW = 8'h00;
   logic       UNLOCK, ARMED, LOCKED, ERR;
   logic [2:0] FAILS;
   int         checks = 0, errors = 0;

   pw_vault #(.PW_W(PW_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC)) dut (
      .CLK(CLK), .RST(RST), .STAGE(STAGE), .PW(PW), .CLR(CLR),
      .UNLOCK(UNLOCK), .ARMED(ARMED), .LOCKED(LOCKED), .ERR(ERR), .FAILS(FAILS)
   );

   always #5 CLK = ~CLK;

   // behavioural model: password-known flag, open flag, remaining locked cycles
   bit         m_have, m_open, m_err;
   int         m_lock, m_fails;
   logic [7:0] m_set;
   logic [1:0] m_prev;

   task automatic model_reset();
      m_have = 0; m_open = 0; m_err = 0; m_lock = 0; m_fails = 0; m_set = 8'h00; m_prev = 2'd0;
   endtask

   task automatic model_step(input logic [1:0] s, input logic [7:0] p, input logic c);
      m_err = 0;
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (m_open) begin
         if (c) begin m_open = 0; m_have = 0; m_set = 8'h00; end
         else if (m_prev == 2'd3 && s == 2'd0) m_open = 0;
      end else if (m_have) begin
         if (m_prev == 2'd2 && s == 2'd3) begin
            if (p == m_set) begin m_open = 1; m_fails = 0; end
            else begin
               m_err = 1;
               m_fails++;
               if (m_fails == MAX_FAIL) m_lock = LOCK_CYC;
            end
         end
      end else begin
         if (m_prev == 2'd0 && s == 2'd1) m_set = p;
         else if (m_prev == 2'd1 && s == 2'd2) begin
            if (p == m_set) m_have = 1;
            else m_err = 1;
         end
      end
      m_prev = s;
   endtask

   function automatic logic [6:0] model_out();
      return {m_open, (m_have && !m_open && m_lock == 0), (m_lock > 0), m_err, 3'(m_fails)};
   endfunction

   function automatic logic [6:0] outs();
      return {UNLOCK, ARMED, LOCKED, ERR, FAILS};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] s, input logic [7:0] p, input logic c);
      STAGE = s; PW = p; CLR = c;
      model_step(s, p, c);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; STAGE = 2'd0; PW = 8'h00; CLR = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic arm_and_lock(input logic [7:0] p);
      step(2'd1, p, 1'b0);
      step(2'd2, p, 1'b0);
      for (int i = 0; i < MAX_FAIL; i++) begin
         step(2'd3, 8'h00, 1'b0);
         chk("try_err", ERR, 1);
         chk("try_fails", FAILS, i + 1);
         chk("try_locked", LOCKED, i == MAX_FAIL - 1);
         if (i < MAX_FAIL - 1) begin
            step(2'd0, 8'h00, 1'b0);
            step(2'd1, 8'h00, 1'b0);
            step(2'd2, 8'h00, 1'b0);
         end
      end
   endtask

   typedef struct {logic [1:0] s; logic [7:0] p; logic c; logic [6:0] e;} vec_t;
   vec_t tbl[$];

   task automatic add(input logic [1:0] s, input logic [7:0] p, input logic c, input logic [6:0] e);
      vec_t v;
      v.s = s; v.p = p; v.c = c; v.e = e;
      tbl.push_back(v);
   endtask

   initial begin
      int locked_cnt, errs_seen;
      logic [1:0] cur, s;
      logic [7:0] p;
      // expected fields: {UNLOCK, ARMED, LOCKED, ERR, FAILS}
      add(2'd0, 8'h00, 1'b0, 7'b0_0_0_0_000);
      add(2'd1, 8'hA5, 1'b0, 7'b0_0_0_0_000);
      add(2'd2, 8'h5A, 1'b0, 7'b0_0_0_1_000);
      add(2'd2, 8'h5A, 1'b0, 7'b0_0_0_0_000);
      add(2'd3, 8'h5A, 1'b0, 7'b0_0_0_0_000);
      add(2'd0, 8'h00, 1'b0, 7'b0_0_0_0_000);
      add(2'd1, 8'h3C, 1'b0, 7'b0_0_0_0_000);
      add(2'd2, 8'h3C, 1'b0, 7'b0_1_0_0_000);
      add(2'd3, 8'h00, 1'b0, 7'b0_1_0_1_001);
      add(2'd0, 8'h00, 1'b0, 7'b0_1_0_0_001);
      add(2'd1, 8'h00, 1'b0, 7'b0_1_0_0_001);
      add(2'd2, 8'h00, 1'b1, 7'b0_1_0_0_001);
      add(2'd3, 8'h3C, 1'b0, 7'b1_0_0_0_000);
      add(2'd0, 8'h00, 1'b0, 7'b0_1_0_0_000);
      add(2'd1, 8'h00, 1'b0, 7'b0_1_0_0_000);
      add(2'd2, 8'h00, 1'b0, 7'b0_1_0_0_000);
      add(2'd3, 8'h3C, 1'b0, 7'b1_0_0_0_000);
      add(2'd3, 8'h00, 1'b1, 7'b0_0_0_0_000);
      add(2'd0, 8'h00, 1'b0, 7'b0_0_0_0_000);
      add(2'd2, 8'h00, 1'b0, 7'b0_0_0_0_000);
      add(2'd3, 8'h00, 1'b0, 7'b0_0_0_0_000);
      add(2'd0, 8'h00, 1'b1, 7'b0_0_0_0_000);
      add(2'd1, 8'h11, 1'b0, 7'b0_0_0_0_000);
      add(2'd2, 8'h11, 1'b0, 7'b0_1_0_0_000);

      do_reset();
      chk("reset_state", outs(), 7'b0);
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].p, tbl[i].c);
         chk($sformatf("vec%0d", i), outs(), tbl[i].e);
      end

      do_reset();
      step(2'd1, 8'hA5, 1'b0);
      chk("setup_no_err", ERR, 0);
      step(2'd2, 8'hA5, 1'b0);
      chk("setup_armed", ARMED, 1);
      chk("setup_no_err2", ERR, 0);
      for (int i = 0; i < MAX_FAIL; i++) begin
         step(2'd3, 8'h00, 1'b0);
         chk("lock_try_err", ERR, 1);
         chk("lock_try_fails", FAILS, i + 1);
         chk("lock_try_locked", LOCKED, i == MAX_FAIL - 1);
         if (i < MAX_FAIL - 1) begin
            step(2'd0, 8'h00, 1'b0);
            step(2'd1, 8'h00, 1'b0);
            step(2'd2, 8'h00, 1'b0);
         end
      end
      locked_cnt = 1;
      errs_seen = 0;
      for (int k = 0; k < 40 && LOCKED; k++) begin
         step(2'(k < 3 ? k : 3), 8'hA5, 1'b0);
         if (ERR) errs_seen++;
         if (LOCKED) locked_cnt++;
      end
      chk("lock_len", locked_cnt, LOCK_CYC);
      chk("lock_no_err", errs_seen, 0);
      chk("post_lock_armed", ARMED, 1);
      chk("post_lock_fails", FAILS, 0);
      chk("post_lock_unlock", UNLOCK, 0);
      step(2'd0, 8'h00, 1'b0);
      step(2'd1, 8'h00, 1'b0);
      step(2'd2, 8'h00, 1'b0);
      step(2'd3, 8'hA5, 1'b0);
      chk("unlock", UNLOCK, 1);
      chk("unlock_fails", FAILS, 0);
      step(2'd0, 8'h00, 1'b1);
      chk("clr_unlock", UNLOCK, 0);
      chk("clr_armed", ARMED, 0);

      do_reset();
      arm_and_lock(8'hA5);
      step(2'd3, 8'h00, 1'b0);
      step(2'd3, 8'h00, 1'b0);
      chk("pre_rst_locked", LOCKED, 1);
      #3;
      RST = 1'b1;
      STAGE = 2'd0;
      model_reset();
      #1;
      chk("rst_async", outs(), 7'b0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      step(2'd2, 8'h00, 1'b0);
      chk("jump_no_event", outs(), 7'b0);
      step(2'd2, 8'h00, 1'b0);
      chk("jump_hold", outs(), 7'b0);

      do_reset();
      cur = 2'd0;
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = $urandom_range(0, 9);
         s = r < 3 ? cur : (r < 9 ? 2'(cur + 2'd1) : 2'($urandom_range(0, 3)));
         r = $urandom_range(0, 9);
         p = r < 5 ? 8'hA5 : (r < 8 ? 8'h3C : 8'($urandom));
         step(s, p, $urandom_range(0, 19) == 0);
         chk("rand", outs(), model_out());
         cur = s;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
